// File: rtl/game_state_ctrl.sv
// Game-flow controller: three synchronised/debounced buttons drive a
// START/MENU/PLAY/PAUSE/FINISH machine with a song cursor and FINISH timeout.
module game_state_ctrl #(
    parameter int NUM_SONGS       = 4,
    parameter int SONG_W          = $clog2(NUM_SONGS),
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FINISH_TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              red_button,
    input  logic              blue_button,
    input  logic              yellow_button,
    input  logic              finish,
    output logic [2:0]        state,
    output logic [SONG_W-1:0] song_sel,
    output logic [SONG_W-1:0] song_confirm,
    output logic              song_start,
    output logic              play_en,
    output logic              paused
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W  = (FINISH_TIMEOUT > 1) ? $clog2(FINISH_TIMEOUT) : 1;
    localparam int BTN_RED    = 0;
    localparam int BTN_BLUE   = 1;
    localparam int BTN_YELLOW = 2;

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_MENU   = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [SONG_W-1:0] r_song_sel;
    logic [SONG_W-1:0] w_song_sel_next;
    logic [SONG_W-1:0] r_song_confirm;
    logic [SONG_W-1:0] w_song_confirm_next;
    logic              r_song_start;
    logic              w_song_start_next;
    logic              r_play_en;
    logic              r_paused;
    logic [2:0]        w_raw;
    logic [2:0]        w_press;
    logic              w_timeout;

    assign w_raw = {yellow_button, blue_button, red_button};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_deb;
            logic             r_deb_prev;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_deb      <= 1'b0;
                    r_deb_prev <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_raw[gi];
                    r_sync2    <= r_sync1;
                    r_deb_prev <= r_deb;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        // This edge is the DEBOUNCE_CYCLES-th stable mismatch.
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_press[gi] = r_deb & ~r_deb_prev;
        end

        if (FINISH_TIMEOUT > 0) begin : g_timeout
            logic [TO_W-1:0] r_to_cnt;

            // Held at zero outside FINISH, so it starts clean on every entry.
            always_ff @(posedge clk) begin
                if (rst || r_state != S_FINISH) begin
                    r_to_cnt <= '0;
                end else if (!w_timeout) begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end

            assign w_timeout = (r_state == S_FINISH) &&
                               (r_to_cnt == TO_W'(FINISH_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_next        = r_state;
        w_song_sel_next     = r_song_sel;
        w_song_confirm_next = r_song_confirm;
        w_song_start_next   = 1'b0;
        case (r_state)
            S_START: begin
                if (w_press[BTN_RED]) w_state_next = S_MENU;
            end
            S_MENU: begin
                if (w_press[BTN_YELLOW]) begin
                    w_state_next        = S_PLAY;
                    w_song_confirm_next = r_song_sel;
                    w_song_start_next   = 1'b1;
                end else if (w_press[BTN_BLUE]) begin
                    if (r_song_sel == SONG_W'(NUM_SONGS - 1))
                        w_song_sel_next = '0;
                    else
                        w_song_sel_next = r_song_sel + SONG_W'(1);
                end
            end
            S_PLAY: begin
                if (finish)                 w_state_next = S_FINISH;
                else if (w_press[BTN_BLUE]) w_state_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_press[BTN_RED])       w_state_next = S_MENU;
                else if (w_press[BTN_BLUE]) w_state_next = S_PLAY;
            end
            S_FINISH: begin
                if (w_press[BTN_YELLOW] || w_timeout) w_state_next = S_MENU;
            end
            default: w_state_next = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_START;
            r_song_sel     <= '0;
            r_song_confirm <= '0;
            r_song_start   <= 1'b0;
            r_play_en      <= 1'b0;
            r_paused       <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_song_sel     <= w_song_sel_next;
            r_song_confirm <= w_song_confirm_next;
            r_song_start   <= w_song_start_next;
            r_play_en      <= (w_state_next == S_PLAY);
            r_paused       <= (w_state_next == S_PAUSE);
        end
    end

    assign state        = r_state;
    assign song_sel     = r_song_sel;
    assign song_confirm = r_song_confirm;
    assign song_start   = r_song_start;
    assign play_en      = r_play_en;
    assign paused       = r_paused;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with NUM_SONGS=3, DEBOUNCE_CYCLES=4,
// FINISH_TIMEOUT=20; expected values are hand-derived button latencies.
module tb_game_state_ctrl;

    localparam int NS = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          red, blue, yellow, finish;
    logic [2:0]    state;
    logic [SW-1:0] song_sel, song_confirm;
    logic          song_start, play_en, paused;

    int n_total = 0;
    int n_bad   = 0;

    game_state_ctrl #(
        .NUM_SONGS(NS),
        .SONG_W(SW),
        .DEBOUNCE_CYCLES(4),
        .FINISH_TIMEOUT(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .red_button(red),
        .blue_button(blue),
        .yellow_button(yellow),
        .finish(finish),
        .state(state),
        .song_sel(song_sel),
        .song_confirm(song_confirm),
        .song_start(song_start),
        .play_en(play_en),
        .paused(paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: red    = v;
            1: blue   = v;
            default: yellow = v;
        endcase
    endtask

    // Raise a button and stop just after the edge where its press acts
    // (first sampled at edge N, state updates at edge N+6).
    task automatic press_evt(input int b);
        set_btn(b, 1'b1);
        tick(7);
    endtask

    task automatic release_btn(input int b);
        set_btn(b, 1'b0);
        tick(8);
    endtask

    task automatic press_full(input int b);
        press_evt(b);
        release_btn(b);
    endtask

    initial begin
        rst = 1'b1; red = 0; blue = 0; yellow = 0; finish = 0;
        tick(1);
        chk("rst_state_1", state, 0);
        chk("rst_sel_1", song_sel, 0);
        tick(1);
        chk("rst_state_2", state, 0);
        chk("rst_conf", song_confirm, 0);
        chk("rst_start", song_start, 0);
        chk("rst_play_en", play_en, 0);
        chk("rst_paused", paused, 0);
        rst = 1'b0;

        // 3-cycle red glitch in START: filtered.
        red = 1'b1;
        tick(3);
        red = 1'b0;
        tick(10);
        chk("glitch_state", state, 0);

        // Red press: state flips exactly at the 6th edge after first sample.
        red = 1'b1;
        tick(6);
        chk("red_pre_edge6", state, 0);
        tick(1);
        chk("red_edge6", state, 1);
        tick(3);
        red = 1'b0;
        tick(8);
        chk("red_release_menu", state, 1);

        // 4-cycle blue pulse in MENU: accepted.
        blue = 1'b1;
        tick(4);
        blue = 1'b0;
        tick(8);
        chk("deb4_sel", song_sel, 1);

        press_full(1); chk("wrap_sel_a", song_sel, 2);
        press_full(1); chk("wrap_sel_b", song_sel, 0);
        press_full(1); chk("wrap_sel_c", song_sel, 1);
        press_full(1); chk("wrap_sel_d", song_sel, 2);

        // Yellow confirm: song_start for exactly one cycle.
        yellow = 1'b1;
        tick(6);
        chk("conf_pre_state", state, 1);
        chk("conf_pre_start", song_start, 0);
        tick(1);
        chk("conf_state", state, 2);
        chk("conf_song", song_confirm, 2);
        chk("conf_start", song_start, 1);
        chk("conf_play_en", play_en, 1);
        tick(1);
        chk("conf_start_drop", song_start, 0);
        release_btn(2);

        // Pause / resume / abort.
        press_evt(1);
        chk("pause_state", state, 3);
        chk("pause_paused", paused, 1);
        chk("pause_play_en", play_en, 0);
        release_btn(1);
        press_evt(1);
        chk("resume_state", state, 2);
        chk("resume_no_start", song_start, 0);
        chk("resume_paused", paused, 0);
        release_btn(1);
        press_full(1);
        chk("pause2_state", state, 3);
        press_evt(0);
        chk("abort_state", state, 1);
        chk("abort_conf", song_confirm, 2);
        release_btn(0);

        // finish beats a simultaneous blue press in PLAY.
        press_full(2);
        chk("play2_state", state, 2);
        blue = 1'b1;
        tick(6);
        finish = 1'b1;
        tick(1);
        chk("prio_state", state, 4);
        finish = 1'b0;
        blue = 1'b0;

        // Timeout: MENU on the 20th edge spent in FINISH.
        tick(19);
        chk("to_edge19", state, 4);
        tick(1);
        chk("to_edge20", state, 1);
        tick(8);

        // Yellow first sampled at FINISH edge 5 -> MENU at edge 11.
        press_full(2);
        chk("play3_state", state, 2);
        finish = 1'b1;
        tick(1);
        chk("fin3_state", state, 4);
        finish = 1'b0;
        tick(4);
        yellow = 1'b1;
        tick(6);
        chk("fy_pre", state, 4);
        tick(1);
        chk("fy_menu", state, 1);
        chk("fy_sel_kept", song_sel, 2);
        release_btn(2);

        // Reset mid-play.
        press_full(2);
        chk("play4_state", state, 2);
        rst = 1'b1;
        tick(1);
        chk("mrst_state", state, 0);
        chk("mrst_sel", song_sel, 0);
        chk("mrst_conf", song_confirm, 0);
        chk("mrst_play_en", play_en, 0);
        rst = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
